// File: rtl/fir_pkg.sv
// Shared definitions for the 18x54 transposed FIR chain and its output stages.
package fir_pkg;

  localparam int FIR_XW    = 18;
  localparam int FIR_YW    = 54;
  localparam int FIR_ORDER = 5;

  // Clip limits of a signed w-bit sample, usable for any output width
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(FIR_XW);
  localparam longint SAT_MIN = sat_min(FIR_XW);

  typedef struct packed {
    logic [FIR_XW-1:0] data;
    logic              valid;
  } fir_stream_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count, sync reset and flush.
// The head register keeps its last value once the FIFO drains.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW:0]      count
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push, pop;

  always_comb begin
    pop      = rd_en && (count_q != '0);
    push     = wr_en && ((count_q != FULL) || pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    head_d   = head_q;
    // A write into an otherwise empty FIFO bypasses straight to the head
    if (count_d != '0) begin
      if ((count_q - CW'(pop)) == '0) begin
        head_d = wr_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign rd_data  = head_q;
  assign rd_valid = (count_q != '0);
  assign count    = count_q;

endmodule

// File: rtl/fir_out_scaler.sv
// Rounds and saturates the FIR accumulator to an output sample, drops the
// pipeline-fill samples, and buffers results on a valid/ready stream.
module fir_out_scaler
  import fir_pkg::*;
#(
  parameter int WIDTH_IN   = FIR_YW,
  parameter int WIDTH_OUT  = FIR_XW,
  parameter int SHIFT      = 8,
  parameter int SKIP       = FIR_ORDER + 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 flush,
  input  logic [WIDTH_IN-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf,
  output logic [15:0]          sat_cnt
);

  localparam int WI  = WIDTH_IN + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 2;
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  localparam logic signed [WI-1:0] ROUND_K = WI'(1) << (SHIFT - 1);
  localparam logic signed [WI-1:0] SAT_HI  = WI'(sat_max(WIDTH_OUT));
  localparam logic signed [WI-1:0] SAT_LO  = WI'(sat_min(WIDTH_OUT));

  logic signed [WI-1:0] in_ext;
  logic signed [WI-1:0] s1_data_q, s1_data_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH_OUT-1:0] s2_data_q, s2_data_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [SKW-1:0]       skip_q, skip_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          sat_cnt_q, sat_cnt_d;
  logic [WIDTH_OUT-1:0] clip_val;
  logic                 clip;
  logic                 accept;
  logic                 fifo_wr;
  logic [AW:0]          fifo_count;
  logic [CW-1:0]        credit;

  // Credits count everything already in flight, so the FIFO can never be
  // written while full even though pops only free space a cycle later.
  always_comb begin
    in_ext   = $signed({in_data[WIDTH_IN-1], in_data});
    credit   = CW'(fifo_count) + CW'(s1_valid_q) + CW'(s2_valid_q);
    in_ready = !flush && (credit < CW'(FIFO_DEPTH));
    accept   = in_valid && in_ready && ena;

    clip     = 1'b0;
    clip_val = s1_data_q[WIDTH_OUT-1:0];
    if (s1_data_q > SAT_HI) begin
      clip     = 1'b1;
      clip_val = SAT_HI[WIDTH_OUT-1:0];
    end else if (s1_data_q < SAT_LO) begin
      clip     = 1'b1;
      clip_val = SAT_LO[WIDTH_OUT-1:0];
    end

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    skip_d     = skip_q;
    sat_cnt_d  = sat_cnt_q;
    ovf_d      = ovf_q || (in_valid && ena && !in_ready);
    fifo_wr    = 1'b0;

    if (ena) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_data_d = (in_ext + ROUND_K) >>> SHIFT;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = clip_val;
      end
      if (s1_valid_q && clip && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_d = sat_cnt_q + 16'd1;
      end
      // Fill samples still leave stage 2 normally but never reach the FIFO
      if (s2_valid_q) begin
        if (skip_q != '0) begin
          skip_d = skip_q - SKW'(1);
        end else begin
          fifo_wr = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      skip_q     <= SKW'(SKIP);
      ovf_q      <= 1'b0;
      sat_cnt_q  <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      skip_q     <= SKW'(SKIP);
      ovf_q      <= 1'b0;
      sat_cnt_q  <= sat_cnt_q;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      skip_q     <= skip_d;
      ovf_q      <= ovf_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH_OUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (fifo_wr),
    .wr_data  (s2_data_q),
    .rd_en    (out_ready),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .count    (fifo_count)
  );

  assign ovf     = ovf_q;
  assign sat_cnt = sat_cnt_q;

endmodule
